caught_loot_tracker: RTL

Holds the loot item currently attached to the hook and produces the caught-loot drawing request (type, inside-rectangle flag, X/Y offsets) that the VGA loot selector gives priority over the matrix loot. It latches a grab event from the hook/matrix collision logic and issues a one-cycle clear request to the loot matrix. It moves the loot with the hook once per frame and holds the item at the base for a short display window. It then reports delivery to the score logic.

---
 rtl/loot_pkg.sv | 36 +++
 rtl/caught_loot_tracker_if.sv | 34 +++
 rtl/loot_rect_hit.sv | 43 ++++
 rtl/caught_loot_tracker.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/loot_pkg.sv
// Shared loot definitions: item type encoding, default sprite size, tracker states
// and the clamped hook-to-loot coordinate helper.
package loot_pkg;

  localparam int unsigned COORD_W    = 11;
  localparam int unsigned LOOT_W_DEF = 32;
  localparam int unsigned LOOT_H_DEF = 32;

  typedef enum logic [2:0] {
    LOOT_EMPTY   = 3'd0,
    LOOT_GOLD_S  = 3'd1,
    LOOT_GOLD_L  = 3'd2,
    LOOT_STONE   = 3'd3,
    LOOT_DIAMOND = 3'd4
  } loot_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ATTACHED = 2'd1,
    ST_DELIVER  = 2'd2
  } trk_state_t;

  // One extra bit beyond 12 so base+offset near 2047 cannot wrap before clamping.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] base,
                                                     input int signed off);
    logic signed [12:0] s;
    s = $signed({2'b00, base}) + 13'(off);
    if (s < 13'sd0)
      return '0;
    else if (s > 13'sd2047)
      return 11'h7FF;
    else
      return s[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/caught_loot_tracker_if.sv
// Hook/matrix/VGA side signals of the caught-loot tracker.
interface caught_loot_tracker_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] hook_topLeftX;
  logic [10:0] hook_topLeftY;
  logic        grab;
  logic [2:0]  grab_loot_type;
  logic        drop;
  logic        hook_at_base;
  logic [2:0]  caught_loot_type;
  logic        caught_loot_ir;
  logic [10:0] caught_loot_offestX;
  logic [10:0] caught_loot_offestY;
  logic        matrix_clear_req;
  logic        loot_delivered;
  logic [2:0]  delivered_type;
  logic        busy;

  modport master (
    output startOfFrame, pixelX, pixelY, hook_topLeftX, hook_topLeftY,
           grab, grab_loot_type, drop, hook_at_base,
    input  caught_loot_type, caught_loot_ir, caught_loot_offestX, caught_loot_offestY,
           matrix_clear_req, loot_delivered, delivered_type, busy
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, hook_topLeftX, hook_topLeftY,
           grab, grab_loot_type, drop, hook_at_base,
    output caught_loot_type, caught_loot_ir, caught_loot_offestX, caught_loot_offestY,
           matrix_clear_req, loot_delivered, delivered_type, busy
  );
endinterface

// File: rtl/loot_rect_hit.sv
// Registered point-in-rectangle test returning the hit flag and pixel offsets.
module loot_rect_hit #(
  parameter int unsigned W = 32,
  parameter int unsigned H = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic [10:0] rect_x,
  input  logic [10:0] rect_y,
  output logic        ir,
  output logic [10:0] off_x,
  output logic [10:0] off_y
);

  logic [11:0] px, py, rx, ry;
  logic        hit_c;

  // 12-bit compares keep rect+size from wrapping at the right/bottom edge.
  always_comb begin
    px    = {1'b0, pixel_x};
    py    = {1'b0, pixel_y};
    rx    = {1'b0, rect_x};
    ry    = {1'b0, rect_y};
    hit_c = enable && (px >= rx) && (px < rx + 12'(W)) &&
                      (py >= ry) && (py < ry + 12'(H));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir    <= 1'b0;
      off_x <= '0;
      off_y <= '0;
    end else begin
      ir    <= hit_c;
      off_x <= hit_c ? 11'(pixel_x - rect_x) : '0;
      off_y <= hit_c ? 11'(pixel_y - rect_y) : '0;
    end
  end

endmodule

// File: rtl/caught_loot_tracker.sv
// Tracks the loot on the hook: grab latch, matrix clear, per-frame follow,
// base display window, delivery pulse and the caught-loot draw request.
module caught_loot_tracker
  import loot_pkg::*;
#(
  parameter int unsigned LOOT_W         = LOOT_W_DEF,
  parameter int unsigned LOOT_H         = LOOT_H_DEF,
  parameter int signed   HOOK_OFX       = -8,
  parameter int signed   HOOK_OFY       = 16,
  parameter int unsigned DELIVER_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  caught_loot_tracker_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DELIVER_FRAMES + 1);

  trk_state_t         state, state_nxt;
  logic [2:0]         type_q, type_nxt;
  logic [COORD_W-1:0] loot_x, loot_x_nxt, loot_y, loot_y_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt, cnt_inc;
  logic               clear_q, clear_nxt;
  logic               deliv_q, deliv_nxt;
  logic [2:0]         deliv_type_q, deliv_type_nxt;
  logic               busy_q;
  logic [COORD_W-1:0] hook_lx, hook_ly;
  logic               grab_ok, deliver_done;

  assign hook_lx      = clamp_coord(bus.hook_topLeftX, HOOK_OFX);
  assign hook_ly      = clamp_coord(bus.hook_topLeftY, HOOK_OFY);
  assign grab_ok      = bus.grab && (bus.grab_loot_type != LOOT_EMPTY);
  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign deliver_done = bus.startOfFrame && (cnt_inc == CNT_W'(DELIVER_FRAMES));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      type_q       <= '0;
      loot_x       <= '0;
      loot_y       <= '0;
      cnt_q        <= '0;
      clear_q      <= 1'b0;
      deliv_q      <= 1'b0;
      deliv_type_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      type_q       <= type_nxt;
      loot_x       <= loot_x_nxt;
      loot_y       <= loot_y_nxt;
      cnt_q        <= cnt_nxt;
      clear_q      <= clear_nxt;
      deliv_q      <= deliv_nxt;
      deliv_type_q <= deliv_type_nxt;
      busy_q       <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state logic; drop always takes priority over reaching the base.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (grab_ok) state_nxt = ST_ATTACHED;
      ST_ATTACHED: if (bus.drop) state_nxt = ST_IDLE;
                   else if (bus.hook_at_base) state_nxt = ST_DELIVER;
      ST_DELIVER:  if (bus.drop || deliver_done) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    type_nxt       = type_q;
    loot_x_nxt     = loot_x;
    loot_y_nxt     = loot_y;
    cnt_nxt        = cnt_q;
    clear_nxt      = 1'b0;
    deliv_nxt      = 1'b0;
    deliv_type_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (grab_ok) begin
          type_nxt   = bus.grab_loot_type;
          loot_x_nxt = hook_lx;
          loot_y_nxt = hook_ly;
          clear_nxt  = 1'b1;
          cnt_nxt    = '0;
        end
      end
      ST_ATTACHED: begin
        if (bus.drop) begin
          type_nxt = '0;
        end else if (bus.hook_at_base) begin
          cnt_nxt = '0;
        end else if (bus.startOfFrame) begin
          loot_x_nxt = hook_lx;
          loot_y_nxt = hook_ly;
        end
      end
      ST_DELIVER: begin
        if (bus.drop) begin
          type_nxt = '0;
        end else if (bus.startOfFrame) begin
          cnt_nxt = cnt_inc;
          if (deliver_done) begin
            deliv_nxt      = 1'b1;
            deliv_type_nxt = type_q;
            type_nxt       = '0;
          end
        end
      end
      default: type_nxt = '0;
    endcase
  end

  loot_rect_hit #(
    .W (LOOT_W),
    .H (LOOT_H)
  ) u_hit (
    .clk     (clk),
    .reset   (reset),
    .enable  ((state == ST_ATTACHED) || (state == ST_DELIVER)),
    .pixel_x (bus.pixelX),
    .pixel_y (bus.pixelY),
    .rect_x  (loot_x),
    .rect_y  (loot_y),
    .ir      (bus.caught_loot_ir),
    .off_x   (bus.caught_loot_offestX),
    .off_y   (bus.caught_loot_offestY)
  );

  assign bus.caught_loot_type = type_q;
  assign bus.matrix_clear_req = clear_q;
  assign bus.loot_delivered   = deliv_q;
  assign bus.delivered_type   = deliv_type_q;
  assign bus.busy             = busy_q;

endmodule
